// File: rtl/queue_release_controller.sv
// Light-phase controller for one approach: drains its queue counter while green,
// then steps through yellow and all-red before handing control back to the arbiter.
module queue_release_controller #(
    parameter int MIN_GREEN        = 4,
    parameter int MAX_GREEN        = 12,
    parameter int YELLOW_TIME      = 2,
    parameter int ALL_RED_TIME     = 1,
    parameter int RELEASE_INTERVAL = 2
) (
    input  logic       traffic_clk,
    input  logic       reset,
    input  logic       go,
    input  logic       cross_request,
    input  logic       car_in_queue,
    input  logic [3:0] car_queue_counter,
    input  logic       add_car_to_queue,
    output logic       dec_car_in_queue,
    output logic       green,
    output logic       yellow,
    output logic       red,
    output logic       phase_done,
    output logic [7:0] cars_released
);

    localparam int GW        = $clog2(MAX_GREEN + 1);
    localparam int PHASE_MAX = (YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int RW        = $clog2(RELEASE_INTERVAL + 1);

    localparam logic [GW-1:0] GREEN_LAST     = GW'(MAX_GREEN - 1);
    localparam logic [GW-1:0] GREEN_MIN_LAST = GW'(MIN_GREEN - 1);
    localparam logic [PW-1:0] YELLOW_LAST    = PW'(YELLOW_TIME - 1);
    localparam logic [PW-1:0] ALL_RED_LAST   = PW'(ALL_RED_TIME - 1);
    localparam logic [RW-1:0] REL_LOAD       = RW'(RELEASE_INTERVAL - 1);

    typedef enum logic [1:0] {
        S_RED     = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_ALL_RED = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] green_cnt, green_cnt_nxt;
    logic [PW-1:0] phase_cnt, phase_cnt_nxt;
    logic [RW-1:0] rel_cnt, rel_cnt_nxt;
    logic          phase_done_nxt;

    always_ff @(posedge traffic_clk or negedge reset) begin
        if (!reset) begin
            state         <= S_RED;
            green_cnt     <= '0;
            phase_cnt     <= '0;
            rel_cnt       <= '0;
            phase_done    <= 1'b0;
            cars_released <= '0;
        end else begin
            state      <= state_nxt;
            green_cnt  <= green_cnt_nxt;
            phase_cnt  <= phase_cnt_nxt;
            rel_cnt    <= rel_cnt_nxt;
            phase_done <= phase_done_nxt;
            if (dec_car_in_queue && cars_released != 8'hFF)
                cars_released <= cars_released + 8'd1;
        end
    end

    // Arbiter handshake: go is a level sampled only in RED while phase_done is low;
    // phase_done is a one-cycle pulse in the first RED cycle after a phase or empty skip.
    always_comb begin
        state_nxt        = state;
        green_cnt_nxt    = '0;
        phase_cnt_nxt    = '0;
        rel_cnt_nxt      = '0;
        phase_done_nxt   = 1'b0;
        dec_car_in_queue = 1'b0;
        case (state)
            S_RED: begin
                if (go && !phase_done) begin
                    if (car_in_queue) state_nxt = S_GREEN;
                    else              phase_done_nxt = 1'b1;
                end
            end
            S_GREEN: begin
                // An arrival blocks the release this cycle; rel_cnt stays 0 so it retries.
                dec_car_in_queue = (rel_cnt == '0) && car_in_queue && !add_car_to_queue;
                if (dec_car_in_queue)   rel_cnt_nxt = REL_LOAD;
                else if (rel_cnt != '0) rel_cnt_nxt = rel_cnt - 1'b1;
                green_cnt_nxt = green_cnt + 1'b1;
                if (green_cnt == GREEN_LAST ||
                    (green_cnt >= GREEN_MIN_LAST && (!car_in_queue || cross_request))) begin
                    state_nxt     = S_YELLOW;
                    green_cnt_nxt = '0;
                    rel_cnt_nxt   = '0;
                end
            end
            S_YELLOW: begin
                if (phase_cnt == YELLOW_LAST) state_nxt = S_ALL_RED;
                else                          phase_cnt_nxt = phase_cnt + 1'b1;
            end
            S_ALL_RED: begin
                if (phase_cnt == ALL_RED_LAST) begin
                    state_nxt      = S_RED;
                    phase_done_nxt = 1'b1;
                end else begin
                    phase_cnt_nxt = phase_cnt + 1'b1;
                end
            end
            default: state_nxt = S_RED;
        endcase
    end

    assign green  = (state == S_GREEN);
    assign yellow = (state == S_YELLOW);
    assign red    = (state == S_RED) || (state == S_ALL_RED);

    // The occupancy flag must always agree with the counter it summarises.
    a_queue_flag_consistent: assert property (
        @(posedge traffic_clk) disable iff (!reset)
        car_in_queue == (car_queue_counter != 4'd0));

endmodule

// File: tb/tb_queue_release_controller.sv
// Directed bench: the controller paired with a small queue counter model, checking
// release timing, phase lengths, handshake pulses, reset behaviour and saturation.
module tb_queue_release_controller;

    logic       traffic_clk = 1'b0;
    logic       reset;
    logic       go;
    logic       cross_request;
    logic       car_in_queue;
    logic [3:0] car_queue_counter = 4'd0;
    logic       add_car_to_queue;
    logic       dec_car_in_queue;
    logic       green, yellow, red, phase_done;
    logic [7:0] cars_released;

    logic       load_en;
    logic [3:0] load_val;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_total = 0;
    logic [31:0] exp_q[$];

    queue_release_controller dut (
        .traffic_clk       (traffic_clk),
        .reset             (reset),
        .go                (go),
        .cross_request     (cross_request),
        .car_in_queue      (car_in_queue),
        .car_queue_counter (car_queue_counter),
        .add_car_to_queue  (add_car_to_queue),
        .dec_car_in_queue  (dec_car_in_queue),
        .green             (green),
        .yellow            (yellow),
        .red               (red),
        .phase_done        (phase_done),
        .cars_released     (cars_released)
    );

    // clock / reset
    always #5 traffic_clk = ~traffic_clk;

    // queue counter model: arrival has priority over release
    always @(posedge traffic_clk) begin
        if (load_en)               car_queue_counter <= load_val;
        else if (add_car_to_queue) car_queue_counter <= car_queue_counter + 4'd1;
        else if (dec_car_in_queue) car_queue_counter <= car_queue_counter - 4'd1;
    end
    assign car_in_queue = (car_queue_counter != 4'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge traffic_clk);
        #1;
    endtask

    task automatic load_queue(input logic [3:0] v);
        load_val = v;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
    endtask

    task automatic run_phase(input string tag, input logic [3:0] q0, input int add_cyc,
                             input int cross_cyc, input int exp_len,
                             input logic [15:0] exp_mask, input logic [3:0] exp_qend);
        int gc, n, yc, arc;
        load_queue(q0);
        go = 1'b1;
        step();
        go = 1'b0;
        check({tag, "_green_entry"}, {31'd0, green}, 32'd1);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (exp_mask[i]) begin
                exp_q.push_back(i);
                n++;
            end
        end
        exp_total = (exp_total + n > 255) ? 255 : exp_total + n;
        gc = 0;
        while (green && gc < 40) begin
            add_car_to_queue = (gc == add_cyc);
            cross_request    = (gc >= cross_cyc);
            #1;
            if (dec_car_in_queue) begin
                if (exp_q.size() == 0) check({tag, "_rel_extra"}, gc, 32'd999);
                else                   check({tag, "_rel_cycle"}, gc, exp_q.pop_front());
            end
            @(posedge traffic_clk);
            #1;
            gc++;
        end
        add_car_to_queue = 1'b0;
        cross_request    = 1'b0;
        check({tag, "_rel_missing"}, exp_q.size(), 32'd0);
        exp_q.delete();
        check({tag, "_green_len"}, gc, exp_len);
        yc = 0;
        while (yellow && yc < 10) begin
            check({tag, "_dec_in_yellow"}, {31'd0, dec_car_in_queue}, 32'd0);
            yc++;
            step();
        end
        check({tag, "_yellow_len"}, yc, 32'd2);
        arc = 0;
        while (red && !phase_done && arc < 10) begin
            arc++;
            step();
        end
        check({tag, "_all_red_len"}, arc, 32'd1);
        check({tag, "_done_pulse"}, {31'd0, phase_done}, 32'd1);
        check({tag, "_red_at_done"}, {31'd0, red}, 32'd1);
        step();
        check({tag, "_done_single"}, {31'd0, phase_done}, 32'd0);
        check({tag, "_queue_end"}, {28'd0, car_queue_counter}, {28'd0, exp_qend});
        check({tag, "_released"}, {24'd0, cars_released}, exp_total);
    endtask

    initial begin
        reset = 1'b0;
        go = 1'b0;
        cross_request = 1'b0;
        add_car_to_queue = 1'b0;
        load_en = 1'b0;
        load_val = 4'd0;
        #1;
        check("rst_red",      {31'd0, red},              32'd1);
        check("rst_green",    {31'd0, green},            32'd0);
        check("rst_yellow",   {31'd0, yellow},           32'd0);
        check("rst_dec",      {31'd0, dec_car_in_queue}, 32'd0);
        check("rst_done",     {31'd0, phase_done},       32'd0);
        check("rst_released", {24'd0, cars_released},    32'd0);
        #12 reset = 1'b1;
        step();

        // name, queue, add cycle, cross cycle, green length, release mask, queue at end
        run_phase("t1_q3",       4'd3,  -1, 99, 6,  16'h0015, 4'd0);
        run_phase("t2_q15",      4'd15, -1, 99, 12, 16'h0555, 4'd9);
        run_phase("t3_add",      4'd5,   0, 99, 12, 16'h0AAA, 4'd0);
        run_phase("t5_cross",    4'd10, -1,  1, 4,  16'h0005, 4'd8);

        // empty skip, with go held a second cycle while phase_done is high
        load_queue(4'd0);
        go = 1'b1;
        #1;
        check("t4_dec", {31'd0, dec_car_in_queue}, 32'd0);
        step();
        check("t4_done",  {31'd0, phase_done}, 32'd1);
        check("t4_red",   {31'd0, red},        32'd1);
        check("t4_green", {31'd0, green},      32'd0);
        step();
        go = 1'b0;
        check("t4_go_ignored", {31'd0, phase_done}, 32'd0);
        check("t4_no_green",   {31'd0, green},      32'd0);
        check("t4_released",   {24'd0, cars_released}, exp_total);

        // reset between edges in the middle of green
        load_queue(4'd10);
        go = 1'b1;
        step();
        go = 1'b0;
        check("t6_green", {31'd0, green}, 32'd1);
        step();
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check("t6_red",      {31'd0, red},              32'd1);
        check("t6_green_lo", {31'd0, green},            32'd0);
        check("t6_dec",      {31'd0, dec_car_in_queue}, 32'd0);
        check("t6_released", {24'd0, cars_released},    32'd0);
        exp_total = 0;
        step();
        @(negedge traffic_clk) reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_no_done", {31'd0, phase_done}, 32'd0);
            check("t6_stay_red", {31'd0, red},       32'd1);
        end

        // repeated full phases drive cars_released into saturation
        for (int p = 0; p < 44; p++)
            run_phase("sat", 4'd15, -1, 99, 12, 16'h0555, 4'd9);
        check("sat_final", {24'd0, cars_released}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
